fsm3_rr_sched: RTL
==================

Name: fsm3_rr_sched

Overview:
- Shares one "101" serial sequence-detector next-state datapath (Moore, states A/B/C/D, match in D) among NCH independent bit-stream requesters.
- Keeps a 2-bit detector context per channel and grants one bit per cycle round-robin.
- Reports per-match events and keeps per-channel saturating match counters.
- Sits between serial front-end channels and the status/interrupt logic.

Parameters:
- NCH, 4, number of requester channels (2..16)
- CNT_W, 8, width of each per-channel match counter
- CH_W, $clog2(NCH), channel index width (derived, not overridden)

Ports:
- clk  in  1  clock
- areset  in  1  reset, asynchronous, active-high
- req_valid  in  NCH  per-channel: a bit is offered
- req_bit  in  NCH  per-channel offered serial bit
- req_ready  out  NCH  one-hot grant; bit i consumed when req_valid[i] & req_ready[i]
- clr  in  1  synchronous clear of all contexts, counters and pointer
- match_valid  out  1  registered one-cycle pulse: a consumed bit drove its channel into D
- match_ch  out  CH_W  channel of the match; 0 when match_valid=0
- rd_ch  in  CH_W  counter read select
- rd_cnt  out  CNT_W  combinational read of cnt[rd_ch]; 0 if rd_ch>=NCH

Behaviour:
- Reset (areset high, async): ctx[i]=A, cnt[i]=0, last-grant pointer=NCH-1 (channel 0 highest priority), match_valid=0, match_ch=0.
- Grant:
  - req_ready is combinational from req_valid and the pointer.
  - Scan starts at pointer+1 modulo NCH; the first valid channel wins.
  - At most one bit per cycle. Pointer updates to the winner only on a consume.
  - No valid channels: req_ready=0 and pointer holds.
- Context update: only the granted channel's ctx changes at the clock edge, using transitions:
  - A: in?B:A
  - B: in?B:C
  - C: in?D:A
  - D: in?B:C
  - All other channels hold.
- Match:
  - If the updated ctx of the consumed channel is D, then next cycle match_valid=1 and match_ch=channel. Latency is 1 cycle after consume.
  - Otherwise match_valid=0 that cycle.
  - Overlapping patterns count: 1,0,1,0,1 gives two matches.
- Counter: cnt[ch] increments in the same edge that sets match_valid. It saturates at 2^CNT_W-1 and never wraps.
- rd_cnt reflects the registered counter value. A same-edge increment is visible the cycle after.
- clr (sync, priority over everything except areset):
  - In the clr cycle req_ready=0, so no consume occurs.
  - At the edge: all ctx=A, cnt=0, pointer=NCH-1.
  - match_valid=0 in the following cycle.
- A channel dropping req_valid mid-pattern keeps its ctx indefinitely. The pattern resumes when it returns.
- areset mid-stream: immediate return to reset values. In-flight bits are lost.

Decomposition:
- Package fsm3_pkg:
  - state typedef enum {A=0,B=1,C=2,D=3} (2 bits)
  - pure function next_state(state, bit) implementing the table above
  - output decode is_match(state)=(state==D)
- Sub-module rr_arbiter (params N):
  - inputs req[N], advance (consume strobe), clr
  - output one-hot gnt[N]
  - holds the pointer internally with the same reset and clr semantics
- The top holds the ctx array, counters, match register and read mux.

Test Plan:
- Channel 0 only, bits 1,0,1 on consecutive cycles -> match_valid=1, match_ch=0 one cycle after third consume; rd_ch=0 gives rd_cnt=1; no other pulses.
- Ch0 (1,0,1) and ch1 (1,1,0,1) both continuously valid -> grants alternate 0,1,0,1,0,1,1; ch0 match after its 3rd grant, ch1 after its 4th; contexts do not interfere.
- Ch2 alone, 1,0,1,0,1 -> two match pulses, match_ch=2, cnt[2]=2; ch3 with 1,1,1 -> no match.
- CNT_W=2, ch1 fed 1,0,1 repeated five times -> five match pulses; cnt[1] stays 3 after the third match.
- Ch0 fed 1,0, then clr for one cycle with req_valid high (req_ready=0), then 1 -> no match; 0,1 afterwards then produces one match.
- All channels valid, areset pulsed asynchronously between edges mid-stream -> match_valid=0 immediately, all rd_cnt=0; first grant after release is channel 0.

Source files
------------

// File: rtl/fsm3_pkg.sv
// Shared "101" Moore detector: state encoding, next-state table and match decode.
package fsm3_pkg;

  typedef enum logic [1:0] {A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3} state_t;

  function automatic state_t next_state(input state_t s, input logic b);
    case (s)
      A:       return b ? B : A;
      B:       return b ? B : C;
      C:       return b ? D : A;
      default: return b ? B : C;
    endcase
  endfunction

  function automatic logic is_match(input state_t s);
    return s == D;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant scanning from last winner + 1; pointer moves only on advance.
module rr_arbiter #(
  parameter  int N    = 4,
  localparam int CH_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            areset,
  input  logic [N-1:0]    req,
  input  logic            advance,
  input  logic            clr,
  output logic [N-1:0]    gnt,
  output logic [CH_W-1:0] gnt_idx
);

  logic [CH_W-1:0] ptr_q, ptr_d;
  logic            found;
  int              idx;

  always_comb begin
    gnt     = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    idx     = 0;
    for (int k = 1; k <= N; k++) begin
      idx = (int'(ptr_q) + k) % N;
      if (!found && req[idx]) begin
        found        = 1'b1;
        gnt[idx]     = 1'b1;
        gnt_idx      = CH_W'(idx);
      end
    end
    // clr blocks every grant so nothing is consumed in the clear cycle
    if (clr) gnt = '0;
  end

  always_comb begin
    ptr_d = ptr_q;
    if (clr)          ptr_d = CH_W'(N - 1);
    else if (advance) ptr_d = gnt_idx;
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) ptr_q <= CH_W'(N - 1);
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/fsm3_rr_sched.sv
// Time-shares one "101" detector datapath across NCH bit streams with per-channel
// context, round-robin grant, match pulse and saturating match counters.
module fsm3_rr_sched
  import fsm3_pkg::*;
#(
  parameter  int NCH   = 4,
  parameter  int CNT_W = 8,
  localparam int CH_W  = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             areset,
  input  logic [NCH-1:0]   req_valid,
  input  logic [NCH-1:0]   req_bit,
  output logic [NCH-1:0]   req_ready,
  input  logic             clr,
  output logic             match_valid,
  output logic [CH_W-1:0]  match_ch,
  input  logic [CH_W-1:0]  rd_ch,
  output logic [CNT_W-1:0] rd_cnt
);

  state_t [NCH-1:0]            ctx_q, ctx_d;
  logic   [NCH-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic                        match_valid_q, match_valid_d;
  logic   [CH_W-1:0]           match_ch_q, match_ch_d;
  logic   [CH_W-1:0]           g;
  logic                        consume;
  state_t                      nxt;

  rr_arbiter #(.N(NCH)) u_arb (
    .clk     (clk),
    .areset  (areset),
    .req     (req_valid),
    .advance (consume),
    .clr     (clr),
    .gnt     (req_ready),
    .gnt_idx (g)
  );

  // grant only ever lands on a valid channel, so any grant is a consume
  assign consume = |(req_valid & req_ready);
  assign nxt     = next_state(ctx_q[g], req_bit[g]);

  always_comb begin
    ctx_d         = ctx_q;
    cnt_d         = cnt_q;
    match_valid_d = 1'b0;
    match_ch_d    = '0;
    if (clr) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_d[i] = A;
        cnt_d[i] = '0;
      end
    end else if (consume) begin
      ctx_d[g] = nxt;
      if (is_match(nxt)) begin
        match_valid_d = 1'b1;
        match_ch_d    = g;
        if (cnt_q[g] != '1) cnt_d[g] = cnt_q[g] + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      for (int i = 0; i < NCH; i++) begin
        ctx_q[i] <= A;
        cnt_q[i] <= '0;
      end
      match_valid_q <= 1'b0;
      match_ch_q    <= '0;
    end else begin
      ctx_q         <= ctx_d;
      cnt_q         <= cnt_d;
      match_valid_q <= match_valid_d;
      match_ch_q    <= match_ch_d;
    end
  end

  assign match_valid = match_valid_q;
  assign match_ch    = match_ch_q;
  assign rd_cnt      = (int'(rd_ch) < NCH) ? cnt_q[rd_ch] : '0;

endmodule
